bcd_seq_ctrl: RTL and testbench

//   Sequential binary-to-BCD converter controller (iterative shift-add-3).

---
 rtl/bcd_seq_ctrl.sv | 86 ++++++++
 tb/tb_bcd_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: iterative double-dabble binary-to-BCD converter with valid/ready handshakes
// Ports: clk/rst (async active-high); in_valid/in_ready/num_in accept one binary word;
//   out_valid/out_ready/bcd_out present the packed BCD result ([3:0]=units); busy while converting.
module bcd_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     num_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int WW = BW + DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  if (10 ** DIGITS <= 2 ** DATA_W) begin : g_chk
    $error("bcd_seq_ctrl: DIGITS too small for DATA_W");
  end
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          state_q, state_d;
  logic [WW-1:0]   work_q, work_d, adj, shifted;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            out_valid_q, out_valid_d, in_ready_q;
  // BCD digits live in the top of the work register; the binary word shifts up into them
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++)
      if (work_q[DATA_W+4*i +: 4] >= 4'd5) adj[DATA_W+4*i +: 4] = work_q[DATA_W+4*i +: 4] + 4'd3;
    shifted = {adj[WW-2:0], 1'b0};
  end
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        state_d = CONV;
        work_d  = {{BW{1'b0}}, num_in};
        cnt_d   = '0;
      end
      CONV: begin
        work_d = shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d     = DONE;
          bcd_d       = shifted[WW-1 -: BW];
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == IDLE);
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign busy      = (state_q == CONV);
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: directed and exhaustive self-checking bench for bcd_seq_ctrl
module tb_bcd_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  num_in = '0;
  logic        in_ready, out_valid, busy;
  logic [11:0] bcd_out;
  int checks = 0, errors = 0;
  bcd_seq_ctrl #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .num_in(num_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] dec(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction
  task automatic start(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(in_ready), 1);
    in_valid = 1'b1;
    num_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic finish_conv(input string tag, input logic [11:0] exp, input int done_edges);
    int n = done_edges;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
  endtask
  task automatic consume(input bit rnd);
    int n = 0;
    do begin
      out_ready = (rnd && n < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end while (!out_ready);
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 0);
    chk("handoff_ready", 32'(in_ready), 1);
  endtask
  logic [7:0]  vals[3] = '{8'd0, 8'd99, 8'd128};
  logic [11:0] exps[3] = '{12'h000, 12'h099, 12'h128};
  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_noeffect", 32'(out_valid), 0);
    start(8'd255);
    chk("c255_busy", 32'(busy), 1);
    chk("c255_in_ready", 32'(in_ready), 0);
    finish_conv("c255", 12'h255, 0);
    consume(0);
    for (int i = 0; i < 3; i++) begin
      start(vals[i]);
      finish_conv("dir", exps[i], 0);
      consume(0);
    end
    start(8'd37);
    finish_conv("bp", 12'h037, 0);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_bcd", 32'(bcd_out), 32'h037);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    consume(0);
    start(8'd200);
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    num_in   = 8'd77;
    chk("hold_bcd_conv", 32'(bcd_out), 32'h037);
    chk("ign_in_ready", 32'(in_ready), 0);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    finish_conv("c200", 12'h200, 5);
    consume(0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no77_busy", 32'(busy), 0);
      chk("no77_valid", 32'(out_valid), 0);
    end
    start(8'd150);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_bcd", 32'(bcd_out), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 0);
    start(8'd45);
    finish_conv("c45", 12'h045, 0);
    consume(0);
    for (int v = 0; v < 256; v++) begin
      start(8'(v));
      finish_conv("ex", dec(v), 0);
      consume(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
